// File: rtl/logic_seq_unit.sv
// Multi-cycle logic/shift execution unit: single-cycle AND/OR/NOR/INV and
// iterative 1-bit-per-cycle logical shifts behind a START/DONE handshake.
module logic_seq_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [2:0]       OPRN,
   input  logic [WIDTH-1:0] OPRND1,
   input  logic [WIDTH-1:0] OPRND2,
   input  logic [CNT_W-1:0] SHAMT,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             ERR
);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_NOR = 3'd2;
   localparam logic [2:0] OP_INV = 3'd3;
   localparam logic [2:0] OP_SLL = 3'd4;
   localparam logic [2:0] OP_SRL = 3'd5;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic [CNT_W-1:0] cnt;

   logic             is_shift;
   logic             shift_step;
   logic             illegal;
   logic [WIDTH-1:0] exec_result;

   assign is_shift   = (op_reg == OP_SLL) || (op_reg == OP_SRL);
   assign shift_step = is_shift && (cnt != '0);
   assign illegal    = op_reg[2] & op_reg[1];

   assign BUSY = (state != ST_IDLE);
   assign DONE = (state == ST_DONE);

   // Value written to RESULT on the completion edge; shifts have already
   // walked acc to its final position by the time cnt reaches zero.
   always_comb begin
      exec_result = '0;
      case (op_reg)
         OP_AND:         exec_result = acc & b_reg;
         OP_OR:          exec_result = acc | b_reg;
         OP_NOR:         exec_result = ~(acc | b_reg);
         OP_INV:         exec_result = ~acc;
         OP_SLL, OP_SRL: exec_result = acc;
         default:        exec_result = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (START) next_state = ST_EXEC;
         ST_EXEC: if (!shift_step) next_state = ST_DONE;
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         acc    <= '0;
         b_reg  <= '0;
         op_reg <= '0;
         cnt    <= '0;
         RESULT <= '0;
         ZERO   <= 1'b1;
         ERR    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  acc    <= OPRND1;
                  b_reg  <= OPRND2;
                  op_reg <= OPRN;
                  cnt    <= SHAMT;
                  ERR    <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (shift_step) begin
                  acc <= (op_reg == OP_SLL) ? (acc << 1) : (acc >> 1);
                  cnt <= cnt - CNT_ONE;
               end else begin
                  RESULT <= exec_result;
                  ZERO   <= (exec_result == '0);
                  ERR    <= illegal;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_seq_unit.sv
// Scoreboard bench for logic_seq_unit: stimulus pushes model results, an
// independent monitor pops and compares them on every DONE pulse.
module tb_logic_seq_unit;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             START = 1'b0;
   logic [2:0]       OPRN = '0;
   logic [WIDTH-1:0] OPRND1 = '0;
   logic [WIDTH-1:0] OPRND2 = '0;
   logic [CNT_W-1:0] SHAMT = '0;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] RESULT;
   logic             ZERO;
   logic             ERR;

   logic_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN),
      .OPRND1(OPRND1), .OPRND2(OPRND2), .SHAMT(SHAMT),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic        err;
      int unsigned done_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_fail = 0;

   logic [31:0] last_res = '0;
   int unsigned last_e = 0;
   int unsigned last_lat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour: whole shift in one step, latency from the op rules.
   function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh,
                                 output logic [31:0] r, output logic e,
                                 output int unsigned lat);
      e   = 1'b0;
      lat = 1;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = ~(a | b);
         3'd3: r = ~a;
         3'd4: begin r = a << sh; lat = 1 + 32'(sh); end
         3'd5: begin r = a >> sh; lat = 1 + 32'(sh); end
         default: begin r = '0; e = 1'b1; end
      endcase
   endfunction

   // Monitor: every DONE pulse consumes exactly one scoreboard entry.
   logic prev_done = 1'b0;
   exp_t m_e;
   always @(negedge CLK) begin
      if (DONE === 1'b1) begin
         check("done_single_pulse", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_done: DONE at cycle %0d, expected no completion", cyc);
         end else begin
            m_e = sb.pop_front();
            check("result", RESULT, m_e.result);
            check("zero", 32'(ZERO), 32'(m_e.zero));
            check("err", 32'(ERR), 32'(m_e.err));
            check("done_cycle", cyc, m_e.done_cyc);
         end
      end
      prev_done = DONE;
   end

   // Issue one op starting at a negedge. mode 0: quiet inputs while busy,
   // 1: scramble inputs, 2: scramble and also pulse START (incl. during DONE).
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit hold, input int mode,
                        input bit expect_b2b);
      logic [31:0] r;
      logic        e;
      int unsigned lat;
      int unsigned cap;
      int          busy_n;
      int          k;
      exp_t        x;
      model(op, a, b, sh, r, e, lat);
      OPRN = op; OPRND1 = a; OPRND2 = b; SHAMT = sh; START = 1'b1;
      k = 0;
      while (BUSY && k < 200) begin
         @(negedge CLK);
         k++;
      end
      if (BUSY) begin
         n_vec++;
         n_fail++;
         $display("FAIL issue_timeout: BUSY stuck at 1, expected 0");
         START = 1'b0;
         return;
      end
      cap = cyc + 1;
      if (expect_b2b) check("b2b_issue_edge", cap, last_e + last_lat + 2);
      x.result = r; x.zero = (r == '0); x.err = e; x.done_cyc = cap + lat;
      sb.push_back(x);
      @(negedge CLK);
      check("capture_busy", 32'(BUSY), 32'd1);
      check("err_clear_on_capture", 32'(ERR), 32'd0);
      check("result_hold", RESULT, last_res);
      last_res = r; last_e = cap; last_lat = lat;
      if (hold) return;
      START = 1'b0;
      busy_n = 1;
      k = 0;
      while (k < 200) begin
         if (mode != 0) begin
            OPRN = 3'($urandom_range(0, 7)); OPRND1 = $urandom; OPRND2 = $urandom;
            SHAMT = 5'($urandom_range(0, 31));
         end
         if (mode == 2) begin
            OPRN  = 3'd0;
            START = DONE ? 1'b1 : 1'($urandom_range(0, 1));
         end
         @(negedge CLK);
         if (!BUSY) begin
            START = 1'b0;
            break;
         end
         busy_n++;
         k++;
      end
      check("busy_length", 32'(busy_n), lat + 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 RST = 1'b0;
      #2;
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_result", RESULT, 32'h0);
      check("rst_zero", 32'(ZERO), 32'd1);
      check("rst_err", 32'(ERR), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Reset during an SLL shift aborts it without a completion.
      OPRN = 3'd4; OPRND1 = 32'h1; OPRND2 = '0; SHAMT = 5'd20; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (5) @(negedge CLK);
      check("mid_shift_busy", 32'(BUSY), 32'd1);
      #2 RST = 1'b0;
      #1;
      check("async_rst_busy", 32'(BUSY), 32'd0);
      check("async_rst_result", RESULT, 32'h0);
      check("async_rst_zero", 32'(ZERO), 32'd1);
      check("async_rst_done", 32'(DONE), 32'd0);
      sb.delete();
      last_res = '0;
      @(negedge CLK);
      RST = 1'b1;
      repeat (30) @(negedge CLK);
      issue(3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 1'b0, 0, 1'b0);

      // Logic ops.
      issue(3'd1, 32'h00000000, 32'h00000000, 5'd3, 1'b0, 0, 1'b0);
      issue(3'd2, 32'h0000FFFF, 32'h00FF0000, 5'd7, 1'b0, 0, 1'b0);
      issue(3'd3, 32'hA5A5A5A5, $urandom, 5'd9, 1'b0, 0, 1'b0);

      // Shift boundaries.
      issue(3'd4, 32'h00000001, $urandom, 5'd31, 1'b0, 0, 1'b0);
      issue(3'd5, 32'h80000000, $urandom, 5'd31, 1'b0, 0, 1'b0);
      issue(3'd4, 32'h80000001, $urandom, 5'd1, 1'b0, 0, 1'b0);
      issue(3'd4, $urandom, $urandom, 5'd0, 1'b0, 0, 1'b0);
      issue(3'd5, $urandom, $urandom, 5'd0, 1'b0, 0, 1'b0);

      // START while busy is ignored; a held START captures on the first IDLE edge.
      issue(3'd5, $urandom, $urandom, 5'd10, 1'b0, 2, 1'b0);
      issue(3'd0, $urandom, $urandom, 5'd2, 1'b1, 0, 1'b0);
      issue(3'd1, $urandom, $urandom, 5'd0, 1'b0, 0, 1'b1);

      // Illegal opcodes and ERR clearing on the next capture.
      issue(3'd0, 32'h12345678, 32'hFFFFFFFF, 5'd0, 1'b0, 0, 1'b0);
      issue(3'd6, $urandom, $urandom, 5'd5, 1'b0, 0, 1'b0);
      issue(3'd0, $urandom, $urandom, 5'd0, 1'b0, 0, 1'b0);
      issue(3'd7, $urandom, $urandom, 5'd0, 1'b0, 1, 1'b0);
      issue(3'd3, $urandom, $urandom, 5'd0, 1'b0, 0, 1'b0);

      // Operand stability after capture.
      issue(3'd4, 32'h0000000F, $urandom, 5'd4, 1'b0, 1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         issue(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'b0, $urandom_range(0, 2), 1'b0);
      end

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_seq_unit.md
Name: logic_seq_unit

Overview:
- Multi-cycle logic/shift execution unit that consumes the 32-bit gate primitives (AND, OR, NOR, inverter) and adds iterative 1-bit-per-cycle shifts.
- Sits directly downstream of the 32-bit logic gate library and feeds the ALU result mux and the zero-flag path.
- Takes a START/DONE handshake from the control unit.
- Registers the result and the zero flag so the datapath sees stable values until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits (must be 32 for the current datapath).
- CNT_W, 5, shift-count width; log2(WIDTH).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only while in IDLE.
- OPRN  input  3  operation select: 0 AND, 1 OR, 2 NOR, 3 INV(OPRND1), 4 SLL, 5 SRL, 6-7 illegal.
- OPRND1  input  WIDTH  operand A; the shift source.
- OPRND2  input  WIDTH  operand B; ignored for INV, SLL and SRL.
- SHAMT  input  CNT_W  shift amount, 0..31.
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  one-cycle completion pulse.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  registered (RESULT == 0).
- ERR  output  1  illegal-opcode flag.

Behaviour:
Clocking and reset:
- One clock (CLK).
- Reset is asynchronous and active-low (RST): RST low forces the state machine to IDLE immediately, regardless of CLK.
- Reset values: BUSY=0, DONE=0, RESULT=32'h0, ZERO=1, ERR=0; internal acc, b_reg, op_reg and cnt are all 0.
- Reset mid-operation aborts the operation with no DONE pulse and no RESULT update.

States:
- IDLE:
  - If START=1 at the clock edge: capture acc<=OPRND1, b_reg<=OPRND2, op_reg<=OPRN, cnt<=SHAMT; clear ERR; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC, logic ops 0-3:
  - RESULT <= acc&b, acc|b, ~(acc|b) or ~acc respectively.
  - Go to DONE.
- EXEC, shift ops 4-5:
  - If cnt==0: RESULT<=acc and go to DONE.
  - Otherwise: acc<=acc<<1 (SLL) or acc>>1 (SRL, logical, zero-fill); cnt<=cnt-1; stay in EXEC.
- EXEC, ops 6-7: RESULT<=0, ERR<=1, go to DONE.
- DONE: DONE=1 for exactly this one cycle, then go to IDLE unconditionally.

Registered outputs:
- ZERO is updated on the same edge as RESULT, from the value being written.
- RESULT, ZERO and ERR hold between completions.

Latency:
- Measured from the START-capture edge E.
- The completion edge (the edge that writes RESULT and enters DONE) is E+1 for logic ops, E+1+SHAMT for shifts.
- DONE is high during the cycle following the completion edge.
- Back-to-back: a new START is accepted no earlier than the edge that ends DONE + 1 (IDLE must be visited for one edge).
- Minimum issue interval: 3 cycles for logic ops, 3+SHAMT cycles for shifts.

Boundary conditions:
- START while BUSY (EXEC or DONE) is ignored: no capture, no queuing.
- Operand, OPRN and SHAMT changes after capture have no effect.
- SHAMT=0 gives the same latency as a logic op; RESULT = OPRND1.
- SHAMT=31 gives 32 cycles in EXEC. The shift does not wrap: bits shifted out are lost.
- An illegal opcode still completes with a DONE pulse; ERR stays high until the next accepted START.

Width rules:
- All operations are exactly WIDTH bits; there is no carry or overflow output.
- cnt counts down and never underflows; it is checked for ==0 before decrementing.

Test Plan:
1. Reset mid-shift:
   - Stimulus: RST low during EXEC of SLL SHAMT=20.
   - Required: BUSY=0 asynchronously, RESULT=0, ZERO=1, no DONE.
   - Then RST high, START AND 32'hFFFF0000 & 32'h0F0F0F0F.
   - Required: DONE on the cycle after E+1; RESULT=32'h0F0F0000, ZERO=0.
2. Logic ops:
   - OR 32'h00000000|32'h00000000 gives RESULT=0, ZERO=1.
   - NOR 32'h0000FFFF,32'h00FF0000 gives RESULT=32'hFF000000.
   - INV 32'hA5A5A5A5 gives RESULT=32'h5A5A5A5A.
   - Each completes with a single DONE pulse.
3. Shifts:
   - SLL 32'h00000001 SHAMT=31: DONE after 33 cycles, RESULT=32'h80000000.
   - SRL 32'h80000000 SHAMT=31: RESULT=32'h00000001.
   - SLL 32'h80000001 SHAMT=1: RESULT=32'h00000002 (no wrap).
   - SHAMT=0: RESULT=OPRND1 with logic-op latency.
4. START while BUSY:
   - Stimulus: pulse START with OPRN=0 and new operands while EXEC of SRL SHAMT=10 is in progress, and again during DONE.
   - Required: both are ignored; RESULT reflects only the SRL.
   - A START held high continuously: the next op is captured on the first IDLE edge after DONE.
5. Illegal opcode:
   - Stimulus: OPRN=6 with a prior RESULT=32'h12345678.
   - Required: DONE pulse, RESULT=0, ZERO=1, ERR=1.
   - Required: the next accepted START (AND) clears ERR on the capture edge.
6. Operand stability:
   - Stimulus: change OPRND1, OPRND2, OPRN and SHAMT every cycle after capture of SLL 32'h0000000F SHAMT=4.
   - Required: RESULT=32'h000000F0; BUSY high for exactly 6 cycles (EXEC ×5, DONE ×1).
